// File: rtl/ones_cnt_sched.sv
// Arbitrating scheduler that shares one ones-counter among N_REQ requesters.
// Define ONES_SCHED_RR_EN for round-robin arbitration; the default is fixed priority, lowest index first.
package q_8_34a_pkg;
  parameter int data_size = 8;
  parameter int r2_size   = 4;
endpackage

module ones_cnt_sched
  import q_8_34a_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic                              clk,
  input  logic                              rst_b,
  input  logic [N_REQ-1:0]                  req,
  input  logic [N_REQ-1:0][data_size-1:0]   req_data,
  output logic [N_REQ-1:0]                  ack,
  output logic [N_REQ-1:0]                  done,
  output logic [r2_size-1:0]                result,
  output logic                              busy,
  output logic                              start,
  output logic [data_size-1:0]              data_in,
  input  logic [r2_size-1:0]                cnt,
  input  logic                              rdy
);

  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, DONE} state_t;

  state_t                r_state, w_next;
  logic [GW-1:0]         r_g, w_gnt;
  logic [data_size-1:0]  r_data_in;
  logic [r2_size-1:0]    r_result;
  logic                  r_start;
  logic                  r_armed;
  logic                  w_take;

  // Arbitration is held off for the first edge after reset release.
  assign w_take = r_armed && (|req);

`ifdef ONES_SCHED_RR_EN
  logic [GW-1:0] r_ptr;
  int            w_idx;

  // Walk from the farthest candidate back to the pointer so the nearest one wins.
  always_comb begin
    w_gnt = '0;
    w_idx = 0;
    for (int k = N_REQ-1; k >= 0; k--) begin
      w_idx = (int'(r_ptr) + k) % N_REQ;
      if (req[w_idx]) w_gnt = GW'(w_idx);
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)                        r_ptr <= '0;
    else if (r_state == IDLE && w_take) r_ptr <= GW'((int'(w_gnt) + 1) % N_REQ);
  end
`else
  always_comb begin
    w_gnt = '0;
    for (int k = N_REQ-1; k >= 0; k--)
      if (req[k]) w_gnt = GW'(k);
  end
`endif

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (w_take) w_next = ISSUE;
      ISSUE:     w_next = WAIT_BUSY;
      WAIT_BUSY: if (!rdy) w_next = WAIT_DONE;
      WAIT_DONE: if (rdy)  w_next = DONE;
      DONE:      w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  always_comb begin
    ack  = '0;
    done = '0;
    if (r_state == ISSUE) ack[r_g]  = 1'b1;
    if (r_state == DONE)  done[r_g] = 1'b1;
    busy = (r_state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_g       <= '0;
      r_data_in <= '0;
      r_result  <= '0;
      r_start   <= 1'b0;
      r_armed   <= 1'b0;
    end else begin
      r_armed <= 1'b1;
      r_start <= (r_state == IDLE) && w_take;
      if (r_state == IDLE && w_take) begin
        r_g       <= w_gnt;
        r_data_in <= req_data[w_gnt];
      end
      if (r_state == WAIT_DONE && rdy) r_result <= cnt;
    end
  end

  assign start   = r_start;
  assign data_in = r_data_in;
  assign result  = r_result;

endmodule

// File: tb/tb_ones_cnt_sched.sv
// Directed bench for ones_cnt_sched with a behavioural ones-counter and a result scoreboard.
module tb_ones_cnt_sched;
  import q_8_34a_pkg::*;

  localparam int N = 4;

  logic                          clk = 1'b0;
  logic                          rst_b;
  logic [N-1:0]                  req;
  logic [N-1:0][data_size-1:0]   req_data;
  logic [N-1:0]                  ack, done;
  logic [r2_size-1:0]            result;
  logic                          busy, start;
  logic [data_size-1:0]          data_in;
  logic [r2_size-1:0]            cnt;
  logic                          rdy;

  ones_cnt_sched #(.N_REQ(N)) dut (
    .clk(clk), .rst_b(rst_b), .req(req), .req_data(req_data),
    .ack(ack), .done(done), .result(result), .busy(busy),
    .start(start), .data_in(data_in), .cnt(cnt), .rdy(rdy)
  );

  always #5 clk = ~clk;

  // Counter model: rdy drops the edge after start, rises four edges later with the count.
  logic [data_size-1:0] c_op;
  logic [2:0]           c_tmr;
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rdy <= 1'b1; cnt <= '0; c_tmr <= '0; c_op <= '0;
    end else if (start) begin
      rdy <= 1'b0; c_tmr <= 3'd3; c_op <= data_in;
    end else if (!rdy) begin
      if (c_tmr == 0) begin
        rdy <= 1'b1;
        cnt <= r2_size'($countones(c_op));
      end else c_tmr <= c_tmr - 3'd1;
    end
  end

  typedef struct { int port; logic [r2_size-1:0] res; } exp_t;
  exp_t sb[$];

  int n_chk = 0, n_pass = 0, start_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push(input int port, input logic [data_size-1:0] d);
    exp_t e;
    e.port = port;
    e.res  = r2_size'($countones(d));
    sb.push_back(e);
  endtask

  // Waits for a done pulse, checks it against the scoreboard head, then drops that requester.
  task automatic wait_done(input bit keep0);
    int   got = -1;
    exp_t e;
    for (int c = 0; c < 60 && got < 0; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) if (done[i]) got = i;
    end
    e = sb.pop_front();
    chk("done_port", 32'(done), 32'(4'b1 << e.port));
    if (got >= 0) begin
      chk("result", 32'(result), 32'(e.res));
      if (!(keep0 && got == 0)) req[got] = 1'b0;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_start"}, 32'(start), 0);
    chk({tag, "_ack"},   32'(ack), 0);
    chk({tag, "_done"},  32'(done), 0);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_din"},   32'(data_in), 0);
    chk({tag, "_res"},   32'(result), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_b = 1'b0;
    sb.delete();
    @(negedge clk);
    chk_zero("rst");
    rst_b = 1'b1;
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (start) start_cnt++;
    if (|ack || |done)
      chk("onehot_excl", {29'b0, $onehot0(ack), $onehot0(done), (|ack) && (|done)}, 32'b110);
  end

  initial begin
    int s0;
    rst_b = 1'b0; req = '0; req_data = '0;
    #1 chk_zero("por");
    do_reset();

    // single job on port 2
    req_data[2] = 8'hB5; req[2] = 1'b1; push(2, 8'hB5);
    @(negedge clk);
    chk("single_ack", 32'(ack), 32'b0100);
    chk("single_start", 32'(start), 1);
    chk("single_din", 32'(data_in), 32'hB5);
    wait_done(1'b0);
    @(negedge clk);
    chk("single_idle_busy", 32'(busy), 0);
    chk("single_res_held", 32'(result), 5);

    // all four at once, each drops after its done
    do_reset();
    req_data = {8'h01, 8'h0F, 8'hFF, 8'h00};
    push(0, 8'h00); push(1, 8'hFF); push(2, 8'h0F); push(3, 8'h01);
    req = 4'b1111;
    for (int j = 0; j < 4; j++) wait_done(1'b0);

    // port 0 holds its request
    do_reset();
    req = 4'b1111;
`ifdef ONES_SCHED_RR_EN
    push(0, 8'h00); push(1, 8'hFF); push(2, 8'h0F); push(3, 8'h01); push(0, 8'h00);
    for (int j = 0; j < 4; j++) wait_done(1'b1);
    wait_done(1'b0);
`else
    for (int j = 0; j < 4; j++) push(0, 8'h00);
    push(1, 8'hFF); push(2, 8'h0F); push(3, 8'h01);
    for (int j = 0; j < 3; j++) wait_done(1'b1);
    for (int j = 0; j < 4; j++) wait_done(1'b0);
`endif

    // reset during WAIT_DONE abandons the job
    do_reset();
    req_data[3] = 8'hFF; req[3] = 1'b1;
    @(negedge clk);
    chk("abort_ack", 32'(ack), 32'b1000);
    @(negedge clk);
    @(negedge clk);
    chk("abort_busy", 32'(busy), 1);
    rst_b = 1'b0; req[3] = 1'b0;
    #1 chk_zero("abort");
    req_data[1] = 8'h81; req[1] = 1'b1;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done), 0);
    end
    rst_b = 1'b1;
    push(1, 8'h81);
    @(negedge clk);
    chk("first_edge_no_ack", 32'(ack), 0);
    @(negedge clk);
    chk("second_edge_ack", 32'(ack), 32'b0010);
    wait_done(1'b0);

    // sweep port 0 back to back, re-requesting during each done cycle
    s0 = start_cnt;
    for (int d = 0; d < 256; d++) begin
      req_data[0] = 8'(d); req[0] = 1'b1; push(0, 8'(d));
      wait_done(1'b0);
    end
    chk("sweep_starts", 32'(start_cnt - s0), 256);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
